// File: rtl/gf_inverse_seq_if.sv
// Byte handshake bundle for the GF(2^8) inverse unit: valid/ready in, held valid/ready out.
interface gf_inverse_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;

  modport master (
    output in_valid,
    output data_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out
  );

  modport slave (
    input  in_valid,
    input  data_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out
  );
endinterface

// File: rtl/gf_inverse_seq.sv
// Sequential GF(2^8) inverse (a^254) by square-and-multiply over one shared multiplier.
// Feeds the AES affine stage; 0x00 maps to 0x00 naturally.
module gf_inverse_seq #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic             clk,
  input  logic             rst,
  gf_inverse_seq_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q;
  logic [7:0] op_q;
  logic [7:0] acc_q;
  logic [3:0] step_q;
  logic [7:0] dout_q;

  logic [7:0] mul_y;
  logic [7:0] prod;

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] a;
    p = 8'h00;
    a = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
    end
    return p;
  endfunction

  // Even steps square, odd steps multiply by the operand.
  assign mul_y = step_q[0] ? op_q : acc_q;
  assign prod  = gf_mul(acc_q, mul_y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 8'h00;
      acc_q   <= 8'h00;
      step_q  <= 4'd0;
      dout_q  <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            op_q    <= bus.data_in;
            acc_q   <= bus.data_in;
            step_q  <= 4'd0;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q <= prod;
          if (step_q == 4'd12) begin
            dout_q  <= prod;
            step_q  <= 4'd0;
            state_q <= StDone;
          end else begin
            step_q <= step_q + 4'd1;
          end
        end
        StDone: begin
          if (bus.out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.data_out  = dout_q;

endmodule

// File: tb/tb_gf_inverse_seq.sv
// Randomised and directed bench for gf_inverse_seq against a brute-force field-inverse model.
module tb_gf_inverse_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf_inverse_seq_if bus ();

  gf_inverse_seq #(.POLY(8'h1B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  logic        bp_rand = 1'b0;
  logic        bp_val  = 1'b1;
  logic        b2b     = 1'b0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  res;
    int unsigned e;
  } txn_t;

  txn_t        q[$];
  logic        prev_ov   = 1'b0;
  logic [7:0]  held      = 8'h00;
  logic        have_last = 1'b0;
  int unsigned last_acc  = 0;

  // Polynomial product then long division by x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (y[i]) p = p ^ (16'(x) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int b = 1; b < 256; b++) if (ref_mul(a, 8'(b)) == 8'h01) return 8'(b);
    return 8'h00;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] s;
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8];
    return s ^ 8'h63;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    bus.out_ready = bp_rand ? 1'($urandom_range(0, 1)) : bp_val;
    @(posedge clk);
    #1;
  end

  // Compare process: checks outputs every cycle against the queued model results.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      prev_ov   = 1'b0;
      held      = 8'h00;
      have_last = 1'b0;
    end else begin
      check("exclusive_ready_valid", 32'(bus.in_ready & bus.out_valid), 32'd0);
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: out_valid=1 data=%0h with nothing pending, expected 0",
                   bus.data_out);
        end else begin
          check("result", 32'(bus.data_out), 32'(q[0].res));
          if (q[0].a != 8'h00)
            check("inverse_product", 32'(ref_mul(q[0].a, bus.data_out)), 32'd1);
          if (!prev_ov) check("latency", cyc - q[0].e, 32'd13);
          held = q[0].res;
          if (bus.out_ready) void'(q.pop_front());
        end
      end else begin
        check("data_out_hold", 32'(bus.data_out), 32'(held));
      end
      if (bus.in_valid && bus.in_ready) begin
        txn_t t;
        t.a   = bus.data_in;
        t.res = ref_inv(bus.data_in);
        t.e   = cyc + 1;
        q.push_back(t);
        if (b2b) begin
          if (have_last) check("period", t.e - last_acc, 32'd15);
          have_last = 1'b1;
        end else begin
          have_last = 1'b0;
        end
        last_acc = t.e;
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic send(input logic [7:0] a);
    int n = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.data_in  = a;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 300);
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.data_in  = 8'($urandom);
  endtask

  task automatic wait_out();
    int n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_timeout: out_valid=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  logic [7:0] va[5] = '{8'h53, 8'hCA, 8'h01, 8'h02, 8'h00};
  logic [7:0] ve[5] = '{8'hCA, 8'h53, 8'h01, 8'h8D, 8'h00};
  logic [7:0] vs[5] = '{8'hED, 8'h74, 8'h7C, 8'h77, 8'h63};

  initial begin
    int ovc;
    bus.in_valid = 1'b0;
    bus.data_in  = 8'h00;
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_data_out", 32'(bus.data_out), 32'd0);

    // Pin the model to known field and S-box values.
    check("model_inv_53", 32'(ref_inv(8'h53)), 32'hCA);
    check("model_inv_02", 32'(ref_inv(8'h02)), 32'h8D);
    check("model_affine_ca", 32'(affine(8'hCA)), 32'hED);
    check("model_affine_00", 32'(affine(8'h00)), 32'h63);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      send(va[i]);
      wait_out();
      check("vector", 32'(bus.data_out), 32'(ve[i]));
      check("vector_affine", 32'(affine(bus.data_out)), 32'(vs[i]));
    end

    // Backpressure: DONE must hold while the consumer stalls.
    bp_val = 1'b0;
    @(posedge clk);
    send(8'h53);
    bus.in_valid = 1'b1;
    bus.data_in  = 8'h02;
    wait_out();
    repeat (20) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_data_out", 32'(bus.data_out), 32'hCA);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end

    // Asynchronous reset between edges while holding a result.
    bus.in_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_data_out", 32'(bus.data_out), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    bp_val = 1'b1;
    @(posedge clk);

    // Abort mid-run at step 6.
    send(8'h53);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    ovc = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) ovc++;
    end
    check("abort_no_output", 32'(ovc), 32'd0);
    send(8'h02);
    wait_out();
    check("after_abort", 32'(bus.data_out), 32'h8D);
    drain();

    b2b = 1'b1;
    for (int a = 0; a < 256; a++) send(8'(a));
    drain();
    b2b = 1'b0;

    bp_rand = 1'b1;
    repeat (40) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(8'($urandom));
    end
    bp_rand = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
